cell_painter: RTL
=================

CELL_PAINTER -- requirements
Module: cell_painter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, pixel colour width (4 bits each of R,G,B).
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, frame-RAM write address width.
REQ-003 SHALL have parameter CELL_PX, default 6, cell edge in pixels.
REQ-004 SHALL have parameters BOARD_COLS, default 10, and BOARD_ROWS, default 20, board size in cells.
REQ-005 SHALL have parameter LINE_W, default 128, frame line stride in pixels (power of two).
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  reset, active low.
REQ-007 SHALL have cmd_valid  in  1  command offered.
REQ-008 SHALL have cmd_ready  out  1  block can accept a command.
REQ-009 SHALL have cmd_op  in  1  0 = paint cell, 1 = clear board.
REQ-010 SHALL have cmd_col  in  4  and  cmd_row  in  5  target cell.
REQ-011 SHALL have cmd_color  in  DATA_WIDTH  fill colour.
REQ-012 SHALL have we  out  1,  addr_w  out  ADDR_WIDTH,  din  out  DATA_WIDTH  frame-RAM write port.
REQ-013 SHALL have done  out  1  one-cycle completion pulse, and cmd_err  out  1  valid alongside done.

Function
REQ-014 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1, registering op, col, row and colour.
REQ-015 SHALL drive cmd_ready 1 only in IDLE.
REQ-016 SHALL use states IDLE -> DRAW -> DONE -> IDLE; an accept moves IDLE to DRAW, the last pixel moves DRAW to DONE, and DONE always returns to IDLE after one cycle.
REQ-017 SHALL register all outputs; the first write (we=1) appears in the cycle after accept, with one pixel per cycle and no gaps.
REQ-018 SHALL, for paint, write CELL_PX x CELL_PX pixels in raster order (px fastest): x = col*CELL_PX+px, y = row*CELL_PX+py, addr_w = y*LINE_W + x.
REQ-019 SHALL colour paint border pixels (px or py equal to 0 or CELL_PX-1) with each 4-bit channel of cmd_color shifted right by 1, and interior pixels with cmd_color.
REQ-020 SHALL, for clear, write all (BOARD_COLS*CELL_PX) x (BOARD_ROWS*CELL_PX) pixels (60x120 = 7200) from (0,0) in raster order, all with cmd_color.
REQ-021 SHALL size intermediate x/y arithmetic to hold the maximum y*LINE_W+x (119*128+59 = 15291) without truncation.
REQ-022 SHALL, for paint with col >= BOARD_COLS or row >= BOARD_ROWS, issue no writes, go DRAW->DONE in one cycle, and set cmd_err=1 with done.
REQ-023 SHALL pulse done for exactly one cycle in DONE; cmd_err is 0 except in that cycle for an erroneous command; cmd_ready returns to 1 the cycle after done.
REQ-024 SHALL keep we=0 outside DRAW; addr_w and din are don't-care when we=0 but held at their last value.
REQ-025 SHALL ignore cmd_valid and all cmd_* inputs outside IDLE; a clear command is never pre-empted.
REQ-026 SHALL give paint latency of accept -> done of exactly CELL_PX*CELL_PX+1 cycles (37), and clear latency of 7201 cycles.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-DRAW, go immediately to IDLE with we=0, addr_w=0, din=0, done=0, cmd_err=0 and internal counters 0, issuing no further writes.
REQ-028 SHALL drive cmd_ready 1 from the first clock edge after rst_n deasserts.

Structure
REQ-029 SHALL place the state enum, the op encoding (OP_PAINT, OP_CLEAR) and the board geometry constants in shared package tetris_pkg.
REQ-030 SHALL implement the px/py raster counter (with width/height inputs and a last flag) as one sub-module, rect_scan; shading and addressing stay in cell_painter.

Verification
REQ-031 SHALL verify paint col=0 row=0 colour 0xF84: 36 writes at addresses 0..5, 128..133, ..., 640..645; corner pixels 0x742, pixel (2,2) 0xF84; done 37 cycles after accept.
REQ-032 SHALL verify paint col=9 row=19 colour 0xFFF: first addr 114*128+54 = 14646, last 15291; border pixels 0x777.
REQ-033 SHALL verify clear colour 0x000: exactly 7200 writes, no address with x>=60 or y>=120, done 7201 cycles after accept.
REQ-034 SHALL verify paint col=10 row=3: zero writes, done and cmd_err both 1 in the same cycle, 1 cycle after accept.
REQ-035 SHALL verify cmd_valid held high with changing cmd_* during DRAW: no second accept until cmd_ready=1, and the second command then executes in full.
REQ-036 SHALL verify rst_n pulled low at write 20 of a clear: we=0 in the same cycle, no writes afterwards, and cmd_ready=1 after release.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the board renderer: painter FSM states, command
// opcodes and the default board geometry.
package tetris_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_PAINT = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    localparam int DEF_CELL_PX    = 6;
    localparam int DEF_BOARD_COLS = 10;
    localparam int DEF_BOARD_ROWS = 20;
    localparam int DEF_LINE_W     = 128;

endpackage

// File: rtl/rect_scan.sv
// Raster counter over a width x height rectangle: px runs fastest, and
// last flags the final coordinate so the caller can stop after it.
module rect_scan #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] width,
    input  logic [W-1:0] height,
    output logic [W-1:0] px,
    output logic [W-1:0] py,
    output logic         last
);

    logic row_end;

    assign row_end = (px == width - W'(1));
    assign last    = row_end && (py == height - W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px <= '0;
            py <= '0;
        end else if (clear) begin
            px <= '0;
            py <= '0;
        end else if (advance) begin
            if (row_end) begin
                px <= '0;
                py <= last ? '0 : py + W'(1);
            end else begin
                px <= px + W'(1);
            end
        end
    end

endmodule

// File: rtl/cell_painter.sv
// Renders one board cell (shaded border) or clears the whole board into the
// frame RAM, one pixel per cycle, with a done/cmd_err completion pulse.
module cell_painter
    import tetris_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 14,
    parameter int CELL_PX    = DEF_CELL_PX,
    parameter int BOARD_COLS = DEF_BOARD_COLS,
    parameter int BOARD_ROWS = DEF_BOARD_ROWS,
    parameter int LINE_W     = DEF_LINE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [3:0]            cmd_col,
    input  logic [4:0]            cmd_row,
    input  logic [DATA_WIDTH-1:0] cmd_color,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  done,
    output logic                  cmd_err
);

    localparam int MAX_SPAN = (BOARD_COLS > BOARD_ROWS ? BOARD_COLS : BOARD_ROWS) * CELL_PX;
    localparam int SCAN_W   = $clog2(MAX_SPAN) + 1;
    localparam int XY_W     = ADDR_WIDTH;

    state_t state, next_state;

    logic                  op_r;
    logic [3:0]            col_r;
    logic [4:0]            row_r;
    logic [DATA_WIDTH-1:0] color_r;
    logic                  scan_end;
    logic                  accept;
    logic                  bad;
    logic                  border;
    logic                  scan_adv;
    logic                  scan_clr;
    logic                  last;
    logic [SCAN_W-1:0]     scan_w, scan_h, px, py;
    logic [XY_W-1:0]       base_x, base_y, x_pos, y_pos, lin_addr;
    logic [DATA_WIDTH-1:0] shaded, pix_color;

    assign accept   = cmd_valid && cmd_ready;
    assign bad      = (op_r == OP_PAINT) &&
                      ((int'(col_r) >= BOARD_COLS) || (int'(row_r) >= BOARD_ROWS));
    assign scan_adv = (state == DRAW) && !bad && !scan_end;
    assign scan_clr = (state != DRAW);
    assign scan_w   = (op_r == OP_CLEAR) ? SCAN_W'(BOARD_COLS * CELL_PX) : SCAN_W'(CELL_PX);
    assign scan_h   = (op_r == OP_CLEAR) ? SCAN_W'(BOARD_ROWS * CELL_PX) : SCAN_W'(CELL_PX);

    rect_scan #(
        .W(SCAN_W)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (scan_clr),
        .advance (scan_adv),
        .width   (scan_w),
        .height  (scan_h),
        .px      (px),
        .py      (py),
        .last    (last)
    );

    // A clear always starts at the board origin; a paint starts at its cell.
    assign base_x   = (op_r == OP_CLEAR) ? '0 : XY_W'(col_r) * XY_W'(CELL_PX);
    assign base_y   = (op_r == OP_CLEAR) ? '0 : XY_W'(row_r) * XY_W'(CELL_PX);
    assign x_pos    = base_x + XY_W'(px);
    assign y_pos    = base_y + XY_W'(py);
    assign lin_addr = y_pos * XY_W'(LINE_W) + x_pos;

    assign border = (op_r == OP_PAINT) &&
                    ((px == '0) || (py == '0) ||
                     (px == SCAN_W'(CELL_PX - 1)) || (py == SCAN_W'(CELL_PX - 1)));

    // Border shade halves each 4-bit channel independently.
    always_comb begin
        shaded = '0;
        for (int ch = 0; ch < DATA_WIDTH / 4; ch++) begin
            shaded[ch*4 +: 4] = {1'b0, color_r[ch*4+1 +: 3]};
        end
    end

    assign pix_color = border ? shaded : color_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = DRAW;
            DRAW:    if (bad || scan_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The last pixel sets scan_end; the following cycle closes the command,
    // which is why a paint takes one cycle more than its pixel count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= OP_PAINT;
            col_r     <= '0;
            row_r     <= '0;
            color_r   <= '0;
            scan_end  <= 1'b0;
            we        <= 1'b0;
            addr_w    <= '0;
            din       <= '0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            we        <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_ready <= (next_state == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r     <= cmd_op;
                        col_r    <= cmd_col;
                        row_r    <= cmd_row;
                        color_r  <= cmd_color;
                        scan_end <= 1'b0;
                    end
                end
                DRAW: begin
                    if (bad || scan_end) begin
                        done    <= 1'b1;
                        cmd_err <= bad;
                    end else begin
                        we       <= 1'b1;
                        addr_w   <= lin_addr;
                        din      <= pix_color;
                        scan_end <= last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
